// File: rtl/i2c_master_ctrl_pkg.sv
// i2c_pkg: shared types and constants for the I2C master transaction controller.
//   i2c_state_e : controller FSM states (4-bit encoding)
//   quarter_t   : index of the current SCL quarter within a bit (q0..q3)
//   ACK / NACK  : SDA level seen on the ninth bit of a byte
//   od_drive()  : open-drain enable needed to put a data bit on SDA
package i2c_pkg;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_START    = 4'd1,
    ST_ADDR     = 4'd2,
    ST_ADDR_ACK = 4'd3,
    ST_WR_LOAD  = 4'd4,
    ST_WR_BYTE  = 4'd5,
    ST_WR_ACK   = 4'd6,
    ST_RD_BYTE  = 4'd7,
    ST_RD_ACK   = 4'd8,
    ST_STOP     = 4'd9
  } i2c_state_e;

  typedef logic [1:0] quarter_t;

  localparam quarter_t Q0 = 2'd0;
  localparam quarter_t Q1 = 2'd1;
  localparam quarter_t Q2 = 2'd2;
  localparam quarter_t Q3 = 2'd3;

  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;

  // A '0' is sent by pulling SDA low; a '1' by releasing it.
  function automatic logic od_drive(input logic data_bit);
    return ~data_bit;
  endfunction

endpackage

// File: rtl/i2c_master_ctrl_if.sv
// i2c_master_ctrl_if: front-end byte-stream handshake plus SCL/SDA pad signals.
//   Front end : en, rw, addr, n_byte, tx_data, tx_valid -> controller
//               tx_ready, rx_data, rx_valid, busy, done, nack_err <- controller
//   Pads      : scl_in, sda_in -> controller; scl_oe, sda_oe (1 = pull low) <- controller
// Modports: master = the I2C master controller, slave = its environment
// (register/DMA front end and pad cells).
interface i2c_master_ctrl_if #(
  parameter int NB_W = 5
);
  logic            en;
  logic            rw;
  logic [6:0]      addr;
  logic [NB_W-1:0] n_byte;
  logic [7:0]      tx_data;
  logic            tx_valid;
  logic            tx_ready;
  logic [7:0]      rx_data;
  logic            rx_valid;
  logic            busy;
  logic            done;
  logic            nack_err;
  logic            scl_in;
  logic            sda_in;
  logic            scl_oe;
  logic            sda_oe;

  modport master (
    input  en, rw, addr, n_byte, tx_data, tx_valid, scl_in, sda_in,
    output tx_ready, rx_data, rx_valid, busy, done, nack_err, scl_oe, sda_oe
  );

  modport slave (
    output en, rw, addr, n_byte, tx_data, tx_valid, scl_in, sda_in,
    input  tx_ready, rx_data, rx_valid, busy, done, nack_err, scl_oe, sda_oe
  );
endinterface

// File: rtl/i2c_master_ctrl_bit_timer.sv
// i2c_bit_timer: divides clk into SCL quarters of QDIV cycles each.
//   clk, resetN : system clock, async active-low reset
//   clr         : hold at the start of q0 (idle / waiting for write data)
//   stall       : hold the count at zero (slave clock stretching)
//   q           : current quarter index
//   q_end       : one-clk strobe on the last cycle of a quarter
module i2c_bit_timer
  import i2c_pkg::*;
#(
  parameter int QDIV = 25
) (
  input  logic     clk,
  input  logic     resetN,
  input  logic     clr,
  input  logic     stall,
  output quarter_t q,
  output logic     q_end
);

  localparam int CW = (QDIV > 1) ? $clog2(QDIV) : 1;

  logic [CW-1:0] cnt_r;
  quarter_t      q_r;

  assign q_end = ~clr & ~stall & (cnt_r == CW'(QDIV - 1));
  assign q     = q_r;

  // Quarter counter; a stall restarts the count so the quarter ends QDIV
  // cycles after the stall is lifted.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      cnt_r <= '0;
      q_r   <= Q0;
    end else if (clr) begin
      cnt_r <= '0;
      q_r   <= Q0;
    end else if (stall) begin
      cnt_r <= '0;
    end else if (q_end) begin
      cnt_r <= '0;
      q_r   <= q_r + 2'd1;
    end else begin
      cnt_r <= cnt_r + CW'(1);
    end
  end

endmodule

// File: rtl/i2c_master_ctrl.sv
// i2c_master_ctrl: clock-divided I2C master transaction controller.
// Generates SCL at f_clk/(4*QDIV), sends START + {addr,rw}, then streams
// n_byte data bytes (write via tx handshake, read via rx pulses) and STOP.
//   clk, resetN : system clock, async active-low reset (releases both lines)
//   bus         : i2c_master_ctrl_if.master (front-end handshake + pads)
// Optional build macro I2C_CLK_STRETCH_EN: when defined, a slave holding SCL
// low during q2 stalls the bit timer; otherwise scl_in is ignored.
module i2c_master_ctrl
  import i2c_pkg::*;
#(
  parameter int QDIV      = 25,
  parameter int MAX_BYTES = 16,
  parameter int NB_W      = $clog2(MAX_BYTES + 1)
) (
  input logic               clk,
  input logic               resetN,
  i2c_master_ctrl_if.master bus
);

  i2c_state_e      state_r;
  logic [7:0]      shift_r;
  logic [2:0]      bit_cnt_r;
  logic [NB_W-1:0] byte_cnt_r;
  logic [NB_W-1:0] n_byte_r;
  logic            rw_r;
  logic            smp_r;
  logic            scl_oe_r;
  logic            sda_oe_r;
  logic            tx_ready_r;
  logic            rx_valid_r;
  logic [7:0]      rx_data_r;
  logic            busy_r;
  logic            done_r;
  logic            nack_err_r;

  quarter_t        q_s;
  logic            q_end_s;
  logic            timer_clr_s;
  logic            stall_s;
  logic [NB_W-1:0] nxt_cnt_s;
  logic            last_bit_s;
  logic            last_byte_s;

  assign timer_clr_s = (state_r == ST_IDLE) || (state_r == ST_WR_LOAD);
  assign nxt_cnt_s   = byte_cnt_r + NB_W'(1);
  assign last_bit_s  = (bit_cnt_r == 3'd7);
  assign last_byte_s = (nxt_cnt_s == n_byte_r);

`ifdef I2C_CLK_STRETCH_EN
  // SCL released by us but still low on the pad: the slave is stretching.
  assign stall_s = (q_s == Q2) && !scl_oe_r && !bus.scl_in;
`else
  logic scl_in_unused_s;
  assign scl_in_unused_s = bus.scl_in;
  assign stall_s         = 1'b0;
`endif

  i2c_bit_timer #(.QDIV(QDIV)) u_timer (
    .clk    (clk),
    .resetN (resetN),
    .clr    (timer_clr_s),
    .stall  (stall_s),
    .q      (q_s),
    .q_end  (q_end_s)
  );

  // Transaction FSM; every output is a register updated here.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_r    <= ST_IDLE;
      shift_r    <= 8'd0;
      bit_cnt_r  <= 3'd0;
      byte_cnt_r <= '0;
      n_byte_r   <= '0;
      rw_r       <= 1'b0;
      smp_r      <= 1'b0;
      scl_oe_r   <= 1'b0;
      sda_oe_r   <= 1'b0;
      tx_ready_r <= 1'b0;
      rx_valid_r <= 1'b0;
      rx_data_r  <= 8'd0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      nack_err_r <= 1'b0;
    end else begin
      tx_ready_r <= 1'b0;
      rx_valid_r <= 1'b0;
      done_r     <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (bus.en) begin
            rw_r       <= bus.rw;
            shift_r    <= {bus.addr, bus.rw};
            n_byte_r   <= (bus.n_byte > NB_W'(MAX_BYTES)) ? NB_W'(MAX_BYTES) : bus.n_byte;
            byte_cnt_r <= '0;
            bit_cnt_r  <= 3'd0;
            nack_err_r <= 1'b0;
            busy_r     <= 1'b1;
            state_r    <= ST_START;
          end
        end
        ST_START: begin
          if (q_end_s) begin
            case (q_s)
              Q1: sda_oe_r <= 1'b1;
              Q2: scl_oe_r <= 1'b1;
              Q3: begin
                sda_oe_r <= od_drive(shift_r[7]);
                state_r  <= ST_ADDR;
              end
              default: ;
            endcase
          end
        end
        ST_ADDR, ST_WR_BYTE: begin
          if (q_end_s) begin
            case (q_s)
              Q1: scl_oe_r <= 1'b0;
              Q3: begin
                scl_oe_r <= 1'b1;
                if (last_bit_s) begin
                  sda_oe_r <= 1'b0;
                  state_r  <= (state_r == ST_ADDR) ? ST_ADDR_ACK : ST_WR_ACK;
                end else begin
                  shift_r   <= {shift_r[6:0], 1'b0};
                  sda_oe_r  <= od_drive(shift_r[6]);
                  bit_cnt_r <= bit_cnt_r + 3'd1;
                end
              end
              default: ;
            endcase
          end
        end
        ST_WR_LOAD: begin
          // SCL stays low (scl_oe_r=1) for as long as the front end stalls.
          if (bus.tx_valid) begin
            shift_r    <= bus.tx_data;
            sda_oe_r   <= od_drive(bus.tx_data[7]);
            bit_cnt_r  <= 3'd0;
            tx_ready_r <= 1'b1;
            state_r    <= ST_WR_BYTE;
          end
        end
        ST_RD_BYTE: begin
          if (q_end_s) begin
            case (q_s)
              Q1: scl_oe_r <= 1'b0;
              Q2: begin
                shift_r <= {shift_r[6:0], bus.sda_in};
                if (last_bit_s) begin
                  rx_data_r  <= {shift_r[6:0], bus.sda_in};
                  rx_valid_r <= 1'b1;
                end
              end
              Q3: begin
                scl_oe_r <= 1'b1;
                if (last_bit_s) begin
                  // ACK every byte but the last, which is NACKed.
                  sda_oe_r <= ~last_byte_s;
                  state_r  <= ST_RD_ACK;
                end else begin
                  bit_cnt_r <= bit_cnt_r + 3'd1;
                end
              end
              default: ;
            endcase
          end
        end
        ST_ADDR_ACK, ST_WR_ACK, ST_RD_ACK: begin
          if (q_end_s) begin
            case (q_s)
              Q1: scl_oe_r <= 1'b0;
              Q2: smp_r    <= bus.sda_in;
              Q3: begin
                scl_oe_r  <= 1'b1;
                sda_oe_r  <= 1'b0;
                bit_cnt_r <= 3'd0;
                if (state_r != ST_ADDR_ACK) begin
                  byte_cnt_r <= nxt_cnt_s;
                end
                if ((state_r != ST_RD_ACK) && (smp_r == NACK)) begin
                  nack_err_r <= 1'b1;
                  sda_oe_r   <= 1'b1;
                  state_r    <= ST_STOP;
                end else if ((state_r == ST_ADDR_ACK) ? (n_byte_r == '0) : last_byte_s) begin
                  sda_oe_r <= 1'b1;
                  state_r  <= ST_STOP;
                end else if ((state_r == ST_RD_ACK) || ((state_r == ST_ADDR_ACK) && rw_r)) begin
                  state_r <= ST_RD_BYTE;
                end else begin
                  state_r <= ST_WR_LOAD;
                end
              end
              default: ;
            endcase
          end
        end
        ST_STOP: begin
          // q0: SCL low, SDA low; q1: SCL high; q2/q3: SDA high (STOP).
          if (q_end_s) begin
            case (q_s)
              Q0: scl_oe_r <= 1'b0;
              Q1: sda_oe_r <= 1'b0;
              Q3: begin
                done_r  <= 1'b1;
                busy_r  <= 1'b0;
                state_r <= ST_IDLE;
              end
              default: ;
            endcase
          end
        end
        default: begin
          scl_oe_r <= 1'b0;
          sda_oe_r <= 1'b0;
          busy_r   <= 1'b0;
          state_r  <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.scl_oe   = scl_oe_r;
  assign bus.sda_oe   = sda_oe_r;
  assign bus.tx_ready = tx_ready_r;
  assign bus.rx_valid = rx_valid_r;
  assign bus.rx_data  = rx_data_r;
  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.nack_err = nack_err_r;

endmodule

// File: tb/tb_i2c_master_ctrl.sv
// tb_i2c_master_ctrl: directed bench for i2c_master_ctrl with a small
// open-drain slave model that records every SCL-high SDA bit.
module tb_i2c_master_ctrl;
  localparam int QDIV      = 4;
  localparam int MAX_BYTES = 16;
  localparam int NB_W      = $clog2(MAX_BYTES + 1);

  logic clk = 1'b0;
  logic resetN = 1'b0;
  always #5 clk = ~clk;

  i2c_master_ctrl_if #(.NB_W(NB_W)) bus ();

  i2c_master_ctrl #(.QDIV(QDIV), .MAX_BYTES(MAX_BYTES), .NB_W(NB_W)) dut (
    .clk    (clk),
    .resetN (resetN),
    .bus    (bus)
  );

  // Open-drain lines: low when either side pulls.
  logic slave_low, stretch_low;
  wire  scl_line = ~bus.scl_oe & ~stretch_low;
  wire  sda_line = ~bus.sda_oe & ~slave_low;
  assign bus.scl_in = scl_line;
  assign bus.sda_in = sda_line;

  int   chk_n = 0;
  int   pass_n = 0;
  logic drv [0:63];
  logic rec [0:63];
  int   rec_cyc [0:63];
  logic [7:0] rxq [0:7];
  int   rec_n, neg_n, stop_n, start_n, txr_n, rxv_n, cyc, stretch_cnt;
  int   stretch_bit = -1;
  logic slave_clr = 1'b1;
  logic prev_scl, prev_sda, active;

  // Slave / monitor: samples lines mid-cycle, drives drv[k] for bit k.
  always @(negedge clk) begin
    cyc      <= cyc + 1;
    prev_scl <= scl_line;
    prev_sda <= sda_line;
    if (slave_clr) begin
      rec_n <= 0; neg_n <= 0; stop_n <= 0; start_n <= 0; txr_n <= 0; rxv_n <= 0;
      active <= 1'b0; slave_low <= 1'b0; stretch_low <= 1'b0; stretch_cnt <= 0;
    end else begin
      if (prev_scl && scl_line && prev_sda && !sda_line) begin
        start_n <= start_n + 1; active <= 1'b1; neg_n <= 0;
      end
      if (prev_scl && scl_line && !prev_sda && sda_line) begin
        stop_n <= stop_n + 1; active <= 1'b0;
      end
      if (active && prev_scl && !scl_line && neg_n < 64) begin
        slave_low <= drv[neg_n];
        neg_n     <= neg_n + 1;
        if (neg_n == stretch_bit) begin
          stretch_low <= 1'b1;
          stretch_cnt <= 2 * QDIV + 100;
        end
      end else if (stretch_cnt > 1) begin
        stretch_cnt <= stretch_cnt - 1;
      end else if (stretch_cnt == 1) begin
        stretch_cnt <= 0;
        stretch_low <= 1'b0;
      end
      if (active && !prev_scl && scl_line && rec_n < 64) begin
        rec[rec_n]     <= sda_line;
        rec_cyc[rec_n] <= cyc;
        rec_n          <= rec_n + 1;
      end
      if (bus.tx_ready) txr_n <= txr_n + 1;
      if (bus.rx_valid && rxv_n < 8) begin
        rxq[rxv_n] <= bus.rx_data;
        rxv_n      <= rxv_n + 1;
      end
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_n++;
    if (got === exp) pass_n++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [7:0] rec_byte(input int base);
    logic [7:0] b = 8'd0;
    for (int i = 0; i < 8; i++) b = {b[6:0], rec[base + i]};
    return b;
  endfunction

  task automatic clear_slave();
    for (int i = 0; i < 64; i++) drv[i] = 1'b0;
    slave_clr = 1'b1;
    repeat (2) @(negedge clk);
    slave_clr = 1'b0;
  endtask

  // Slave ACKs the address and returns the given read bytes.
  task automatic setup_read(input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2);
    logic [7:0] d [3];
    d[0] = d0; d[1] = d1; d[2] = d2;
    drv[8] = 1'b1;
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < 8; i++) drv[9 + 9 * k + i] = ~d[k][7 - i];
  endtask

  task automatic start_xfer(input logic rw, input logic [6:0] addr, input logic [NB_W-1:0] n);
    @(negedge clk);
    bus.en = 1'b1; bus.rw = rw; bus.addr = addr; bus.n_byte = n;
    @(negedge clk);
    bus.en = 1'b0;
  endtask

  task automatic wait_tx_ready(input string tag);
    int k = 0;
    while (bus.tx_ready !== 1'b1 && k < 3000) begin @(negedge clk); k++; end
    check_val({tag, " tx_ready seen"}, 32'(k < 3000), 32'd1);
    @(negedge clk);
  endtask

  task automatic wait_done(input string tag);
    int k = 0;
    while (bus.done !== 1'b1 && k < 5000) begin @(negedge clk); k++; end
    check_val({tag, " done"}, 32'(bus.done), 32'd1);
    check_val({tag, " busy at done"}, 32'(bus.busy), 32'd0);
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_rec(input int n);
    int k = 0;
    while (rec_n < n && k < 3000) begin @(negedge clk); k++; end
    check_val("rec wait", 32'(k < 3000), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int k;
    int bad;
    bus.en = 1'b0; bus.rw = 1'b0; bus.addr = 7'd0; bus.n_byte = '0;
    bus.tx_data = 8'd0; bus.tx_valid = 1'b0;
    for (int i = 0; i < 64; i++) drv[i] = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst scl_oe", 32'(bus.scl_oe), 32'd0);
    check_val("rst sda_oe", 32'(bus.sda_oe), 32'd0);
    check_val("rst busy/done/nack", {29'd0, bus.busy, bus.done, bus.nack_err}, 32'd0);
    check_val("rst rx", {22'd0, bus.rx_data, bus.rx_valid, bus.tx_ready}, 32'd0);
    resetN = 1'b1;
    clear_slave();

    // Write 0x50, two bytes, slave ACKs everything.
    drv[8] = 1'b1; drv[17] = 1'b1; drv[26] = 1'b1;
    bus.tx_data = 8'hA5; bus.tx_valid = 1'b1;
    start_xfer(1'b0, 7'h50, 5'd2);
    check_val("wr busy", 32'(bus.busy), 32'd1);
    wait_tx_ready("wr b0");
    bus.tx_data = 8'h3C;
    wait_tx_ready("wr b1");
    bus.tx_valid = 1'b0;
    wait_done("wr");
    check_val("wr addr byte", 32'(rec_byte(0)), 32'hA0);
    check_val("wr ack0", 32'(rec[8]), 32'd0);
    check_val("wr data0", 32'(rec_byte(9)), 32'hA5);
    check_val("wr ack1", 32'(rec[17]), 32'd0);
    check_val("wr data1", 32'(rec_byte(18)), 32'h3C);
    check_val("wr ack2", 32'(rec[26]), 32'd0);
    check_val("wr tx_ready count", 32'(txr_n), 32'd2);
    check_val("wr nack_err", 32'(bus.nack_err), 32'd0);
    check_val("wr start/stop", 32'(start_n * 16 + stop_n), 32'h11);

    // Read 0x51, three bytes: ACK, ACK, NACK from the master.
    clear_slave();
    setup_read(8'h11, 8'h22, 8'h33);
    start_xfer(1'b1, 7'h51, 5'd3);
    wait_done("rd");
    check_val("rd addr byte", 32'(rec_byte(0)), 32'hA3);
    check_val("rd rx count", 32'(rxv_n), 32'd3);
    check_val("rd rx0", 32'(rxq[0]), 32'h11);
    check_val("rd rx1", 32'(rxq[1]), 32'h22);
    check_val("rd rx2", 32'(rxq[2]), 32'h33);
    check_val("rd master acks", {29'd0, rec[17], rec[26], rec[35]}, 32'd1);
    check_val("rd stop", 32'(stop_n), 32'd1);
    check_val("rd nack_err", 32'(bus.nack_err), 32'd0);

    // Address NACK: nobody answers.
    clear_slave();
    bus.tx_data = 8'hFF; bus.tx_valid = 1'b1;
    start_xfer(1'b0, 7'h50, 5'd2);
    wait_done("nack");
    bus.tx_valid = 1'b0;
    check_val("nack bit", 32'(rec[8]), 32'd1);
    check_val("nack nack_err", 32'(bus.nack_err), 32'd1);
    check_val("nack tx_ready", 32'(txr_n), 32'd0);
    check_val("nack bits then stop", 32'(rec_n), 32'd10);
    check_val("nack stop", 32'(stop_n), 32'd1);

    // n_byte=0 with address ACK: STOP right away, sticky flag cleared.
    clear_slave();
    drv[8] = 1'b1;
    start_xfer(1'b0, 7'h50, 5'd0);
    wait_done("zero");
    check_val("zero nack_err", 32'(bus.nack_err), 32'd0);
    check_val("zero tx_ready", 32'(txr_n), 32'd0);

    // Write data withheld 500 clks in WR_LOAD.
    clear_slave();
    drv[8] = 1'b1; drv[17] = 1'b1;
    start_xfer(1'b0, 7'h2A, 5'd1);
    wait_rec(9);
    repeat (2 * QDIV + 4) @(negedge clk);
    bad = 0;
    for (int i = 0; i < 500; i++) begin
      if (bus.scl_oe !== 1'b1) bad++;
      @(negedge clk);
    end
    check_val("stall scl low", 32'(bad), 32'd0);
    check_val("stall no edges", 32'(rec_n), 32'd9);
    bus.tx_data = 8'h96; bus.tx_valid = 1'b1;
    wait_tx_ready("stall");
    bus.tx_valid = 1'b0;
    wait_done("stall");
    check_val("stall addr", 32'(rec_byte(0)), 32'h54);
    check_val("stall data", 32'(rec_byte(9)), 32'h96);
    check_val("stall ack", 32'(rec[17]), 32'd0);

    // Reset in the middle of a read byte, then a clean new transfer.
    clear_slave();
    setup_read(8'h11, 8'h22, 8'h33);
    start_xfer(1'b1, 7'h51, 5'd3);
    wait_rec(12);
    k = 0;
    while (bus.scl_oe !== 1'b1 && k < 100) begin @(negedge clk); k++; end
    @(negedge clk);
    check_val("mid scl held", 32'(bus.scl_oe), 32'd1);
    #2 resetN = 1'b0;
    #1;
    check_val("async scl_oe", 32'(bus.scl_oe), 32'd0);
    check_val("async sda_oe", 32'(bus.sda_oe), 32'd0);
    check_val("async busy", 32'(bus.busy), 32'd0);
    clear_slave();
    @(negedge clk);
    resetN = 1'b1;
    drv[8] = 1'b1; drv[17] = 1'b1;
    bus.tx_data = 8'hA5; bus.tx_valid = 1'b1;
    start_xfer(1'b0, 7'h50, 5'd1);
    wait_tx_ready("post");
    bus.tx_valid = 1'b0;
    wait_done("post");
    check_val("post start", 32'(start_n), 32'd1);
    check_val("post addr", 32'(rec_byte(0)), 32'hA0);
    check_val("post data", 32'(rec_byte(9)), 32'hA5);

`ifdef I2C_CLK_STRETCH_EN
    // Slave stretches SCL by 100 clks in data bit 3 of a read byte.
    clear_slave();
    setup_read(8'h5A, 8'h00, 8'h00);
    stretch_bit = 12;
    start_xfer(1'b1, 7'h51, 5'd1);
    wait_done("str");
    stretch_bit = -1;
    check_val("str rx", 32'(rxq[0]), 32'h5A);
    check_val("str normal period", 32'(rec_cyc[11] - rec_cyc[10]), 32'(4 * QDIV));
    k = rec_cyc[12] - rec_cyc[11];
    check_val("str stretched period", 32'((k >= 4 * QDIV + 98) && (k <= 4 * QDIV + 102)), 32'd1);
`endif

    $display("%0d/%0d checks passed", pass_n, chk_n);
    $finish;
  end

endmodule

// File: doc/i2c_master_ctrl.md
Name: i2c_master_ctrl

Overview:
Parametrised, clock-divided I2C master transaction controller. Successor to the SCL-edge-driven FSM. Runs on the system clock and generates its own SCL. Handles 7-bit address, multi-byte read/write with a byte-stream handshake, ACK/NACK reporting and open-drain pad enables. Sits between the register/DMA front end and the SCL/SDA pad cells.

Parameters:
QDIV, 25, clk cycles per SCL quarter-period (SCL = f_clk/(4*QDIV)); legal >=2
MAX_BYTES, 16, largest n_byte accepted
NB_W, $clog2(MAX_BYTES+1), width of n_byte and byte counter

Ports:
clk  in  1  system clock
resetN  in  1  reset, asynchronous, active-low
en  in  1  start request, sampled in IDLE only
rw  in  1  0=write, 1=read; captured with en
addr  in  7  slave address; captured with en
n_byte  in  NB_W  data bytes; captured with en; clamped to MAX_BYTES
tx_data  in  8  next write byte
tx_valid  in  1  tx_data valid
tx_ready  out  1  1-cycle pulse: tx_data consumed
rx_data  out  8  received byte
rx_valid  out  1  1-cycle pulse: rx_data updated
busy  out  1  high from en accept until STOP complete
done  out  1  1-cycle pulse at transaction end
nack_err  out  1  sticky NACK flag; cleared on next accepted en
scl_in  in  1  SCL pad input
sda_in  in  1  SDA pad input
scl_oe  out  1  1 = drive SCL low, 0 = release
sda_oe  out  1  1 = drive SDA low, 0 = release

Behaviour:
- Reset values: scl_oe=0, sda_oe=0, tx_ready=0, rx_valid=0, rx_data=0, busy=0, done=0, nack_err=0, state IDLE.
- Assertion of resetN mid-transfer releases both lines immediately. No STOP is generated.
- Bit timing: each bit has four quarters q0..q3, each QDIV clk cycles.
  - q0/q1: SCL low. SDA is updated at the start of q0.
  - q2/q3: SCL released.
  - sda_in is sampled on the last clk of q2.
- States: IDLE, START, ADDR, ADDR_ACK, WR_LOAD, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, STOP.
- IDLE:
  - On en=1: capture rw/addr/n_byte, clear nack_err, set busy, go to START.
  - en while busy is ignored.
- START:
  - Two quarters with SCL released and SDA released.
  - Then SDA low for one quarter.
  - Then SCL low for one quarter, then go to ADDR.
- ADDR: shifts {addr, rw}, MSB first, 8 bits, then goes to ADDR_ACK.
- ADDR_ACK: one bit with SDA released.
  - Sample=1 (NACK): set nack_err, go to STOP.
  - Sample=0 and n_byte=0: go to STOP.
  - Sample=0, rw=0: go to WR_LOAD.
  - Sample=0, rw=1: go to RD_BYTE.
- WR_LOAD:
  - SCL held low. Waits for tx_valid.
  - On tx_valid: latch tx_data, pulse tx_ready, go to WR_BYTE.
  - A stall of any length is legal.
- WR_BYTE: shifts 8 bits, MSB first, then goes to WR_ACK.
- WR_ACK: SDA released; byte counter increments.
  - NACK: set nack_err, go to STOP.
  - Counter==n_byte: go to STOP.
  - Otherwise: go to WR_LOAD.
- RD_BYTE:
  - SDA released; samples 8 bits, MSB first.
  - On the last sample: update rx_data and pulse rx_valid, then go to RD_ACK.
- RD_ACK: byte counter increments.
  - Master drives ACK (sda_oe=1) unless this is the last byte; the last byte gets NACK (sda_oe=0).
  - Last byte: go to STOP. Otherwise: go to RD_BYTE.
- STOP:
  - SCL low with SDA low for one quarter.
  - Then SCL released for one quarter.
  - Then SDA released for two quarters.
  - Then pulse done, clear busy, go to IDLE.
- done and busy fall in the same cycle. done asserts even on NACK.
- Byte counter width is NB_W; compare is exact equality; no wrap is possible due to clamping.
- A simultaneous en and done cycle accepts nothing. en is re-sampled next cycle in IDLE.

Optional Feature:
- Macro: I2C_CLK_STRETCH_EN.
- Defined:
  - The quarter counter does not advance in q2 while scl_oe=0 and scl_in=0, so a slave can stretch the clock.
  - The sample point is re-based to QDIV clks after scl_in is seen high.
- Undefined: scl_in is ignored and timing is purely counter-based.

Decomposition:
- Package i2c_pkg:
  - i2c_state_e enum (4-bit encoding).
  - quarter typedef (2-bit).
  - ACK/NACK constants.
- Sub-module i2c_bit_timer:
  - QDIV divider producing a quarter index and a one-clk q_end strobe.
  - Stall input for clock stretching.
  - The FSM advances only on q_end.

Test Plan:
- Write, addr=0x50, n_byte=2, tx 0xA5,0x3C, slave ACKs all:
  - SDA bit sequence is 0xA0,ACK,0xA5,ACK,0x3C,ACK.
  - Two tx_ready pulses, done=1, nack_err=0.
- Read, addr=0x51, n_byte=3, slave returns 0x11,0x22,0x33:
  - Three rx_valid pulses with those values.
  - Master sends ACK, ACK, NACK, then STOP.
- Address NACK (sda_in held 1): after ADDR_ACK, STOP follows, nack_err=1, done pulse, tx_ready never pulses.
- tx_valid withheld for 500 clks in WR_LOAD: SCL stays low throughout, and the byte is sent correctly once tx_valid rises.
- resetN asserted mid-RD_BYTE: scl_oe=0 and sda_oe=0 immediately; after release, a new en starts cleanly with a START.
- With I2C_CLK_STRETCH_EN, slave holds scl_in low for 100 clks in bit 3: the bit period extends by 100 clks and data is sampled correctly.
